carry_select_adder: RTL and testbench
=====================================

CARRY_SELECT_ADDER -- requirements
Module: carry_select_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand/sum width; legal only as a multiple of BLK_W.
REQ-002 SHALL have parameter BLK_W, default 4: carry-select block width in bits.
REQ-003 SHALL use one clock and an asynchronous, active-low reset.
REQ-004 Port: clk  input  1  rising-edge clock.
REQ-005 Port: rst_n  input  1  asynchronous active-low reset.
REQ-006 Port: in_valid  input  1  high for one cycle per operand pair to capture.
REQ-007 Port: A  input  WIDTH  operand A, two's complement.
REQ-008 Port: B  input  WIDTH  operand B, two's complement.
REQ-009 Port: cin  input  1  carry-in.
REQ-010 Port: out_valid  output  1  sum/cout/of hold a new result.
REQ-011 Port: sum  output  WIDTH  registered A+B+cin, modulo 2^WIDTH.
REQ-012 Port: cout  output  1  registered carry out of bit WIDTH-1.
REQ-013 Port: of  output  1  registered signed-overflow flag.

Function
REQ-014 SHALL compute {cout,sum} = A + B + cin as an unsigned (WIDTH+1)-bit result.
REQ-015 SHALL compute of = (A[MSB] == B[MSB]) AND (sum[MSB] != A[MSB]); cin is not an overflow term.
REQ-016 SHALL split operands into WIDTH/BLK_W blocks; block 0 ripples from cin directly.
REQ-017 Each higher block SHALL precompute sum and carry for carry-in 0 and carry-in 1 in parallel.
REQ-018 Each higher block SHALL select its result with the previous block's real carry through a 2:1 mux.
REQ-019 cout SHALL be the selected carry of the last block.
REQ-020 Adder datapath SHALL be purely combinational from A/B/cin to the output register; no internal pipeline.
REQ-021 Latency SHALL be 1 cycle: when in_valid is high at edge N, sum/cout/of SHALL be valid after edge N and out_valid SHALL be 1.
REQ-022 When in_valid is low at an edge, out_valid SHALL be 0 and sum/cout/of SHALL hold their previous values.
REQ-023 Back-to-back in_valid SHALL produce one result per cycle; no stall, no backpressure.
REQ-024 Wrap-around: 0xFFFFFFFF + 0 + cin=1 SHALL give sum 0, cout 1, of 0.

Reset
REQ-025 While rst_n is low, sum, cout, of and out_valid SHALL be 0 immediately, independent of clk.
REQ-026 Reset asserted mid-operation SHALL discard the pending result; the first capture after release SHALL need a new in_valid.
REQ-027 Reset release SHALL be sampled on clk; the first capture SHALL occur on the first rising edge with rst_n high.

Structure
REQ-028 WIDTH and BLK_W defaults SHALL live in a shared package (adder_pkg) so all adder variants use the same values.
REQ-029 SHALL use one sub-module, csa_block: a BLK_W-bit ripple adder pair (cin 0 / cin 1) with outputs sum0, sum1, c0, c1.
REQ-030 Top level SHALL instantiate csa_block via generate, plus the select muxes, overflow logic and output registers.
REQ-031 The overflow logic MAY be a separate small function or module but SHALL not be a third sub-module requirement.

Verification
REQ-032 Scenario: A=0x7FFFFFFF, B=0x00000001, cin=0 -> sum 0x80000000, cout 0, of 1.
REQ-033 Scenario: A=0xFFFFFFFF, B=0x80000000, cin=0 -> sum 0x7FFFFFFF, cout 1, of 1.
REQ-034 Scenario: A=0x7FFFFFFF, B=0xFFFFFFFF, cin=0 -> sum 0x7FFFFFFE, cout 1, of 0.
REQ-035 Scenario: A=0x00000001, B=0x80000000, cin=0 -> sum 0x80000001, cout 0, of 0.
REQ-036 Scenario: A=B=0xFFFFFFFF, cin=0 -> sum 0xFFFFFFFE, cout 1, of 0; repeat with cin=1 -> sum 0xFFFFFFFF, cout 1, of 0.
REQ-037 Scenario: assert rst_n low between clk edges after a valid result -> sum/cout/of/out_valid read 0 before the next edge; then check 10k random back-to-back vectors against a behavioural A+B+cin model at 1-cycle latency.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared defaults and helpers for every adder variant in this codebase.
// Keeping WIDTH/BLK_W here lets all variants agree on operand and block size.
package adder_pkg;

   localparam int ADDER_WIDTH = 32;
   localparam int ADDER_BLK_W = 4;

   // Two's-complement overflow: equal operand signs produce a result of the other sign.
   function automatic logic signed_overflow(input logic a_msb, input logic b_msb,
                                            input logic s_msb);
      return (a_msb == b_msb) && (s_msb != a_msb);
   endfunction

endpackage

// File: rtl/csa_block.sv
// One carry-select slice: two BLK_W-bit ripple adders evaluated in parallel,
// one assuming carry-in 0 and one assuming carry-in 1.
module csa_block
   import adder_pkg::*;
#(
   parameter int BLK_W = ADDER_BLK_W
) (
   input  logic [BLK_W-1:0] a,
   input  logic [BLK_W-1:0] b,
   output logic [BLK_W-1:0] sum0,
   output logic [BLK_W-1:0] sum1,
   output logic             c0,
   output logic             c1
);

   always_comb begin
      logic [BLK_W:0] k0;
      logic [BLK_W:0] k1;
      // NOTE: every variable gets a default before the loop so no path leaves one unassigned (no latch).
      k0    = '0;
      k1    = '0;
      sum0  = '0;
      sum1  = '0;
      k1[0] = 1'b1;
      for (int i = 0; i < BLK_W; i++) begin
         sum0[i]  = a[i] ^ b[i] ^ k0[i];
         sum1[i]  = a[i] ^ b[i] ^ k1[i];
         k0[i+1]  = (a[i] & b[i]) | (k0[i] & (a[i] ^ b[i]));
         k1[i+1]  = (a[i] & b[i]) | (k1[i] & (a[i] ^ b[i]));
      end
      c0 = k0[BLK_W];
      c1 = k1[BLK_W];
   end

endmodule

// File: rtl/carry_select_adder.sv
// Registered carry-select adder: block 0 ripples from cin, higher blocks pick
// a precomputed result with the real incoming carry; one cycle of latency.
module carry_select_adder
   import adder_pkg::*;
#(
   parameter int WIDTH = ADDER_WIDTH,   // must be a multiple of BLK_W
   parameter int BLK_W = ADDER_BLK_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             cin,
   output logic             out_valid,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             of
);

   localparam int NUM_BLK = WIDTH / BLK_W;

   logic [WIDTH-1:0] sum_comb;
   logic             cout_comb;
   logic             of_comb;

   // Each block owns its carry-out so the chain is one signal per stage.
   for (genvar i = 0; i < NUM_BLK; i++) begin : g_blk
      logic [BLK_W-1:0] blk_sum;
      logic             carry_out;

      if (i == 0) begin : g_ripple
         assign {carry_out, blk_sum} = {1'b0, A[BLK_W-1:0]} + {1'b0, B[BLK_W-1:0]}
                                     + {{BLK_W{1'b0}}, cin};
      end else begin : g_select
         logic [BLK_W-1:0] s0;
         logic [BLK_W-1:0] s1;
         logic             c0;
         logic             c1;

         csa_block #(.BLK_W(BLK_W)) u_blk (
            .a    (A[i*BLK_W +: BLK_W]),
            .b    (B[i*BLK_W +: BLK_W]),
            .sum0 (s0),
            .sum1 (s1),
            .c0   (c0),
            .c1   (c1)
         );

         assign blk_sum   = g_blk[i-1].carry_out ? s1 : s0;
         assign carry_out = g_blk[i-1].carry_out ? c1 : c0;
      end

      assign sum_comb[i*BLK_W +: BLK_W] = blk_sum;
   end

   assign cout_comb = g_blk[NUM_BLK-1].carry_out;
   assign of_comb   = signed_overflow(A[WIDTH-1], B[WIDTH-1], sum_comb[WIDTH-1]);

   // NOTE: state registers use non-blocking assignments and all of them are reset asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         sum       <= '0;
         cout      <= 1'b0;
         of        <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            sum  <= sum_comb;
            cout <= cout_comb;
            of   <= of_comb;
         end
      end
   end

endmodule

// File: tb/tb_carry_select_adder.sv
// Directed corner cases, reset behaviour and random back-to-back vectors for
// carry_select_adder, compared against a plain-arithmetic reference.
module tb_carry_select_adder;

   localparam int W = 32;

   logic         clk      = 1'b0;
   logic         rst_n    = 1'b1;
   logic         in_valid = 1'b0;
   logic [W-1:0] A        = '0;
   logic [W-1:0] B        = '0;
   logic         cin      = 1'b0;
   logic         out_valid;
   logic [W-1:0] sum;
   logic         cout;
   logic         of;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference results of the most recent captured operand pair.
   logic [W-1:0] m_sum  = '0;
   logic         m_cout = 1'b0;
   logic         m_of   = 1'b0;

   always #5 clk = ~clk;

   carry_select_adder #(.WIDTH(W), .BLK_W(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .A         (A),
      .B         (B),
      .cin       (cin),
      .out_valid (out_valid),
      .sum       (sum),
      .cout      (cout),
      .of        (of)
   );

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
      logic [W:0] total;
      total  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
      m_sum  = total[W-1:0];
      m_cout = total[W];
      m_of   = (a[W-1] == b[W-1]) && (m_sum[W-1] != a[W-1]);
   endtask

   // Inputs already driven with in_valid high: expect the result one edge later.
   task automatic capture_and_check(input string tag);
      model(A, B, cin);
      @(posedge clk);
      #1;
      check({tag, ".valid"}, out_valid, 1);
      check({tag, ".sum"},   sum,       m_sum);
      check({tag, ".cout"},  cout,      m_cout);
      check({tag, ".of"},    of,        m_of);
   endtask

   task automatic vec(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic c);
      @(negedge clk);
      A        = a;
      B        = b;
      cin      = c;
      in_valid = 1'b1;
      capture_and_check(tag);
   endtask

   task automatic check_zero(input string tag);
      check({tag, ".valid"}, out_valid, 0);
      check({tag, ".sum"},   sum,       0);
      check({tag, ".cout"},  cout,      0);
      check({tag, ".of"},    of,        0);
   endtask

   initial begin
      // Asynchronous reset between clock edges.
      #1 rst_n = 1'b0;
      #1 check_zero("rst_async");
      in_valid = 1'b1;
      A        = 32'h1234_5678;
      B        = 32'h1111_1111;
      repeat (2) @(posedge clk);
      #1 check_zero("rst_held");

      // First capture on the first rising edge with rst_n high.
      @(negedge clk);
      rst_n    = 1'b1;
      A        = 32'h0000_0003;
      B        = 32'h0000_0004;
      cin      = 1'b1;
      in_valid = 1'b1;
      capture_and_check("first");

      vec("ovf_pos",  32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
      vec("ovf_neg",  32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
      vec("mixed",    32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      vec("no_ovf",   32'h0000_0001, 32'h8000_0000, 1'b0);
      vec("ones_c0",  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      vec("ones_c1",  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
      vec("wrap",     32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
      vec("cin_ovf",  32'h7FFF_FFFF, 32'h0000_0000, 1'b1);
      vec("blk_edge", 32'h0000_000F, 32'h0000_0001, 1'b0);

      // Idle cycle: out_valid drops, result registers keep the last values.
      @(negedge clk);
      in_valid = 1'b0;
      A        = 32'hDEAD_BEEF;
      B        = 32'h0BAD_F00D;
      cin      = 1'b1;
      @(posedge clk);
      #1;
      check("hold.valid", out_valid, 0);
      check("hold.sum",   sum,       m_sum);
      check("hold.cout",  cout,      m_cout);
      check("hold.of",    of,        m_of);

      // Reset mid-operation: a valid result, then rst_n drops before the next edge.
      vec("pre_rst", 32'h8000_0000, 32'h8000_0000, 1'b1);
      #3 rst_n = 1'b0;
      #1 check_zero("rst_mid");
      @(negedge clk);
      rst_n    = 1'b1;
      in_valid = 1'b0;
      @(posedge clk);
      #1 check_zero("post_rst");

      // Random back-to-back vectors, one result per cycle.
      for (int i = 0; i < 10000; i++) begin
         vec($sformatf("rand%0d", i), $urandom, $urandom, 1'($urandom_range(0, 1)));
      end

      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);
      #1 check("drain.valid", out_valid, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
